// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller in front of a combinational instruction memory.
// Owns the fetch PC, buffers fetched words with their PCs in a small prefetch FIFO,
// and hands them to decode over a valid/ready handshake. Branch redirects flush the FIFO.
//
// Ports:
//   clk            - single clock, all state on rising edge
//   rst_n          - synchronous reset, active low
//   fetch_en       - 1 = new fetches allowed
//   imem_addr      - byte address to instruction memory (always even), equals fetch_pc
//   imem_instr     - instruction word for imem_addr, same cycle
//   redirect_valid - one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc    - new fetch byte address (bit 0 ignored)
//   instr_valid    - FIFO head holds a valid instruction
//   instr          - FIFO head instruction word
//   instr_pc       - byte address of instr
//   instr_ready    - decode accepts head when instr_valid & instr_ready
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  state_t          state_next;
  logic [15:0]     fetch_pc;
  logic [15:0]     buf_instr [DEPTH];
  logic [15:0]     buf_pc    [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            valid_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and FIFO push/pop decisions; redirect never changes state
  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    count_next = count;

    case (state)
      IDLE: if (fetch_en)  state_next = RUN;
      RUN:  if (!fetch_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    pop  = valid_q & instr_ready & ~redirect_valid;
    // A full FIFO may still accept a push when the head leaves in the same cycle
    push = (state == RUN) & fetch_en & ~redirect_valid &
           ((count < CW'(DEPTH)) | pop);

    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Fetch PC, FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC & 16'hFFFE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 16'hFFFE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) begin
        buf_instr[wr_ptr] <= imem_instr;
        buf_pc[wr_ptr]    <= fetch_pc;
        wr_ptr            <= wr_ptr + AW'(1);
        fetch_pc          <= fetch_pc + 16'd2;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count   <= count_next;
      valid_q <= (count_next != '0);
    end
  end

  assign imem_addr   = fetch_pc;
  assign instr_valid = valid_q;
  assign instr       = buf_instr[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a queue-based
// reference model of the fetch stream.
module tb_fetch_ctrl;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } entry_t;

  entry_t      q[$];
  logic [15:0] m_pc;
  logic        m_run;

  always #5 clk = ~clk;

  // Instruction memory contents: mem[k] = 16'h1000 + k, word index k = addr/2
  function automatic logic [15:0] mem(input logic [15:0] a);
    return 16'h1000 + {1'b0, a[15:1]};
  endfunction

  assign imem_instr = mem(imem_addr);

  fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one rising edge of the fetch stream
  task automatic model_edge();
    logic do_pop;
    logic do_push;
    if (!rst_n) begin
      q.delete();
      m_pc  = RESET_PC & 16'hFFFE;
      m_run = 1'b0;
    end else begin
      if (redirect_valid) begin
        q.delete();
        m_pc = redirect_pc & 16'hFFFE;
      end else begin
        do_pop  = (q.size() > 0) && instr_ready;
        do_push = m_run && fetch_en && ((q.size() < int'(DEPTH)) || do_pop);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          q.push_back('{pc: m_pc, ins: mem(m_pc)});
          m_pc = m_pc + 16'd2;
        end
      end
      m_run = fetch_en;
    end
  endtask

  task automatic check_model();
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {15'b0, instr_valid}, {15'b0, (q.size() > 0)});
    if (q.size() > 0) begin
      chk("instr", instr, q[0].ins);
      chk("instr_pc", instr_pc, q[0].pc);
    end
  endtask

  // Check at the falling edge, clock, update model, return to the falling edge
  task automatic cycle();
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  logic [15:0] exp_pcs [4];
  logic [15:0] saved_pc;

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    instr_ready    = 1'b0;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_valid", {15'b0, instr_valid}, 16'h0);
    chk("rst_instr", instr, 16'h0);
    chk("rst_instr_pc", instr_pc, 16'h0);
    chk("rst_addr", imem_addr, RESET_PC & 16'hFFFE);

    // 1: sequential stream with no gaps
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", {15'b0, instr_valid}, 16'h1);
      chk("t1_pc", instr_pc, 16'(2 * i));
      chk("t1_instr", instr, 16'(16'h1000 + i));
      cycle();
    end

    // 2: stall saturates the FIFO, then resume without loss
    do_reset();
    fetch_en    = 1'b1;
    instr_ready = 1'b0;
    cycle();
    cycle();
    repeat (6) cycle();
    chk("t2_addr_frozen", imem_addr, 16'(2 * DEPTH));
    chk("t2_instr_hold", instr, 16'h1000);
    chk("t2_valid", {15'b0, instr_valid}, 16'h1);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_pc", instr_pc, 16'(2 * i));
      chk("t2_instr", instr, 16'(16'h1000 + i));
      cycle();
    end

    // 3: redirect while full
    instr_ready = 1'b0;
    cycle();
    cycle();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0041;
    cycle();
    redirect_valid = 1'b0;
    chk("t3_valid_drop", {15'b0, instr_valid}, 16'h0);
    chk("t3_addr", imem_addr, 16'h0040);
    cycle();
    chk("t3_valid", {15'b0, instr_valid}, 16'h1);
    chk("t3_pc", instr_pc, 16'h0040);
    chk("t3_instr", instr, 16'h1020);
    cycle();

    // 4: address wrap after redirect
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    exp_pcs[0] = 16'hFFFC;
    exp_pcs[1] = 16'hFFFE;
    exp_pcs[2] = 16'h0000;
    exp_pcs[3] = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      chk("t4_pc", instr_pc, exp_pcs[i]);
      cycle();
    end

    // 5: fetch_en low drains, then resumes at next sequential PC
    instr_ready = 1'b0;
    cycle();
    cycle();
    saved_pc    = m_pc;
    fetch_en    = 1'b0;
    instr_ready = 1'b1;
    cycle();
    cycle();
    chk("t5_drained", {15'b0, instr_valid}, 16'h0);
    cycle();
    chk("t5_still_empty", {15'b0, instr_valid}, 16'h0);
    chk("t5_addr_hold", imem_addr, saved_pc);
    fetch_en = 1'b1;
    cycle();
    cycle();
    chk("t5_resume_pc", instr_pc, saved_pc);
    cycle();

    // 6: reset with full FIFO and a simultaneous redirect
    instr_ready = 1'b0;
    cycle();
    cycle();
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h1234;
    cycle();
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    chk("t6_valid", {15'b0, instr_valid}, 16'h0);
    chk("t6_addr", imem_addr, RESET_PC & 16'hFFFE);
    chk("t6_instr", instr, 16'h0);
    chk("t6_instr_pc", instr_pc, 16'h0);
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    repeat (4) cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst_n          = ($urandom_range(99) != 0);
      fetch_en       = ($urandom_range(9) != 0);
      instr_ready    = ($urandom_range(2) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = 16'($urandom());
      cycle();
    end
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
